// File: rtl/alu_issue.sv
// Purpose: operand issue + writeback stage feeding an 8-bit ALU, with a 4x8 regfile, forwarding and RAW stall.
// Latency: operands registered at the accept edge N, ALU result registered at N+1, regfile written at N+2.
// Backpressure: instr_ready drops for a RAW hazard on the E stage or when a load wins; ld_ready only when E/W empty.
module alu_issue #(
  parameter int DW    = 8,
  parameter int NREGS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [8:0]    instr,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [1:0]    ld_reg,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [3:0]    alu_opcode,
  output logic          alu_s_or_c,
  input  logic [DW-1:0] alu_result,
  output logic          wb_valid,
  output logic [1:0]    wb_reg,
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          busy
);

  // Architectural register file; 2-bit register fields fix it at four entries.
  logic [DW-1:0] regs [NREGS];

  // Pipeline occupancy: E holds the instruction whose operands sit at the ALU,
  // W holds the one whose result the ALU is presenting this cycle.
  logic       e_v;
  logic [1:0] e_rd;
  logic       w_v;
  logic [1:0] w_rd;

  // Instruction field decode. rd doubles as source A.
  logic [3:0] i_op;
  logic       i_soc;
  logic [1:0] i_rd;
  logic [1:0] i_rs;

  assign i_op  = instr[8:5];
  assign i_soc = instr[4];
  assign i_rd  = instr[3:2];
  assign i_rs  = instr[1:0];

  // A source produced by the instruction in E has no value anywhere yet, so
  // the only option is to wait one cycle until it reaches W and can forward.
  logic hazard_a;
  logic hazard_b;
  logic hazard;

  assign hazard_a = e_v && (e_rd == i_rd);
  assign hazard_b = e_v && (e_rd == i_rs);
  assign hazard   = hazard_a || hazard_b;

  // A source being written by W this edge takes the ALU output directly, so a
  // same-cycle write/read of one register never sees the stale regfile copy.
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;

  assign opnd_a = (w_v && (w_rd == i_rd)) ? alu_result : regs[i_rd];
  assign opnd_b = (w_v && (w_rd == i_rs)) ? alu_result : regs[i_rs];

  // Loads only enter an empty pipeline, which keeps them from racing a
  // writeback to the same register; a load that goes in blocks issue.
  logic ld_acc;
  logic issue;

  assign ld_ready    = reset && !e_v && !w_v;
  assign ld_acc      = ld_valid && ld_ready;
  assign instr_ready = reset && !hazard && !ld_acc;
  assign issue       = instr_valid && instr_ready;

  assign wb_valid = w_v;
  assign wb_reg   = w_rd;
  assign busy     = e_v || w_v;

  // Debug read is raw regfile contents, deliberately without forwarding.
  assign dbg_data = regs[dbg_addr];

  // Regfile update: ALU writeback from W, or an external load (never both).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (w_v) begin
        regs[w_rd] <= alu_result;
      end
      if (ld_acc) begin
        regs[ld_reg] <= ld_data;
      end
    end
  end

  // Advance E/W occupancy; reset drops anything in flight without writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_v  <= 1'b0;
      e_rd <= '0;
      w_v  <= 1'b0;
      w_rd <= '0;
    end else begin
      w_v  <= e_v;
      w_rd <= e_rd;
      e_v  <= issue;
      if (issue) begin
        e_rd <= i_rd;
      end
    end
  end

  // Register ALU operands; bubbles zero the data but keep opcode/select, since
  // the ALU carry register sees every cycle and a stable opcode is harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_opcode <= '0;
      alu_s_or_c <= 1'b0;
    end else if (issue) begin
      alu_in1    <= opnd_a;
      alu_in2    <= opnd_b;
      alu_opcode <= i_op;
      alu_s_or_c <= i_soc;
    end else begin
      alu_in1 <= '0;
      alu_in2 <= '0;
    end
  end

endmodule
